// File: rtl/mem_request_unit_if.sv
// Request/response bundle between the datapath, mem_request_unit and the RAM.
// master: the request unit itself; slave: the datapath/RAM side.
interface mem_request_unit_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
);
    logic              halt_in;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              ihit;
    logic [WORD_W-1:0] iload;
    logic              dhit;
    logic [WORD_W-1:0] dload;
    logic              halt_out;
    logic              mem_err;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic [CNT_W-1:0]  icount;
    logic [CNT_W-1:0]  dcount;

    modport master (
        input  halt_in, iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output ihit, iload, dhit, dload, halt_out, mem_err,
        output ramREN, ramWEN, ramaddr, ramstore, icount, dcount
    );

    modport slave (
        output halt_in, iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  ihit, iload, dhit, dload, halt_out, mem_err,
        input  ramREN, ramWEN, ramaddr, ramstore, icount, dcount
    );
endinterface

// File: rtl/mem_request_unit.sv
// Arbitrates fetch/data requests onto a single-port RAM with bounded retry,
// halt sequencing and saturating per-class access counters.
module mem_request_unit #(
    parameter int WORD_W    = 32,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 16
) (
    input logic                CLK,
    input logic                nRST,
    mem_request_unit_if.master bus
);
    typedef enum logic [2:0] {IDLE, ACC, RETRY, RESP, HALTED} state_t;
    typedef enum logic [1:0] {INSTR, DREAD, DWRITE} kind_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t            state, state_n;
    kind_t             kind, kind_n;
    ramstate_t         rs;
    logic [RW-1:0]     retry, retry_n;
    logic [WORD_W-1:0] addr, addr_n;
    logic [WORD_W-1:0] store, store_n;
    logic [WORD_W-1:0] iload, iload_n;
    logic [WORD_W-1:0] dload, dload_n;
    logic              err, err_n;
    logic              ren, ren_n;
    logic              wen, wen_n;
    logic [CNT_W-1:0]  icnt, icnt_n;
    logic [CNT_W-1:0]  dcnt, dcnt_n;

    assign rs = ramstate_t'(bus.ramstate);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            kind  <= INSTR;
            retry <= '0;
            addr  <= '0;
            store <= '0;
            iload <= '0;
            dload <= '0;
            err   <= 1'b0;
            ren   <= 1'b0;
            wen   <= 1'b0;
            icnt  <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_n;
            kind  <= kind_n;
            retry <= retry_n;
            addr  <= addr_n;
            store <= store_n;
            iload <= iload_n;
            dload <= dload_n;
            err   <= err_n;
            ren   <= ren_n;
            wen   <= wen_n;
            icnt  <= icnt_n;
            dcnt  <= dcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        kind_n  = kind;
        retry_n = retry;
        addr_n  = addr;
        store_n = store;
        iload_n = iload;
        dload_n = dload;
        err_n   = err;
        icnt_n  = icnt;
        dcnt_n  = dcnt;
        unique case (state)
            IDLE: begin
                if (bus.halt_in) begin
                    state_n = HALTED;
                end else if (bus.dWEN || bus.dREN || bus.iREN) begin
                    state_n = ACC;
                    retry_n = '0;
                    store_n = '0;
                    if (bus.dWEN) begin
                        kind_n  = DWRITE;
                        addr_n  = bus.daddr;
                        store_n = bus.dstore;
                    end else if (bus.dREN) begin
                        kind_n = DREAD;
                        addr_n = bus.daddr;
                    end else begin
                        kind_n = INSTR;
                        addr_n = bus.iaddr;
                    end
                end
            end
            ACC: begin
                unique case (rs)
                    ACCESS: begin
                        state_n = RESP;
                        if (kind == INSTR) iload_n = bus.ramload;
                        else if (kind == DREAD) dload_n = bus.ramload;
                        else dload_n = '0;
                    end
                    ERROR: begin
                        if (int'(retry) + 1 < MAX_RETRY) begin
                            retry_n = retry + 1'b1;
                            state_n = RETRY;
                        end else begin
                            err_n   = 1'b1;
                            state_n = HALTED;
                        end
                    end
                    default: ;
                endcase
            end
            RETRY:  state_n = ACC;
            RESP: begin
                state_n = IDLE;
                if (kind == INSTR) begin
                    if (icnt != '1) icnt_n = icnt + 1'b1;
                end else if (dcnt != '1) begin
                    dcnt_n = dcnt + 1'b1;
                end
            end
            HALTED: state_n = HALTED;
            default: state_n = IDLE;
        endcase
        // Strobes follow the next state, so they drop in RETRY/RESP/HALTED.
        ren_n = (state_n == ACC) && (kind_n != DWRITE);
        wen_n = (state_n == ACC) && (kind_n == DWRITE);
    end

    assign bus.ihit     = (state == RESP) && (kind == INSTR);
    assign bus.dhit     = (state == RESP) && (kind != INSTR);
    assign bus.iload    = iload;
    assign bus.dload    = dload;
    assign bus.halt_out = (state == HALTED);
    assign bus.mem_err  = err;
    assign bus.ramREN   = ren;
    assign bus.ramWEN   = wen;
    assign bus.ramaddr  = addr;
    assign bus.ramstore = store;
    assign bus.icount   = icnt;
    assign bus.dcount   = dcnt;
endmodule

// File: tb/tb_mem_request_unit.sv
// Randomized transaction-level bench for mem_request_unit.
// Expected latency, strobes, loads and counts come from a per-transaction model.
module tb_mem_request_unit;
    localparam int W  = 32;
    localparam int MR = 3;
    localparam int CW = 16;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    mem_request_unit_if #(.WORD_W(W), .CNT_W(CW)) bus ();

    mem_request_unit #(
        .WORD_W(W),
        .MAX_RETRY(MR),
        .CNT_W(CW)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;
    logic [CW-1:0] icnt_m = '0;
    logic [CW-1:0] dcnt_m = '0;
    logic [W-1:0] last_i = '0;
    logic [W-1:0] last_d = '0;
    logic [1:0] script[$];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_req();
        bus.halt_in = 1'b0;
        bus.iREN    = 1'b0;
        bus.dREN    = 1'b0;
        bus.dWEN    = 1'b0;
    endtask

    task automatic post_check(input string tag);
        check({tag, "_ctl"}, {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN,
                              bus.halt_out, bus.mem_err}, 0);
        check({tag, "_icount"}, bus.icount, icnt_m);
        check({tag, "_dcount"}, bus.dcount, dcnt_m);
        check({tag, "_iload"}, bus.iload, last_i);
        check({tag, "_dload"}, bus.dload, last_d);
    endtask

    // k: 0 fetch, 1 data read, 2 data write. nerr >= MR means fatal.
    task automatic access(input logic [1:0] k, input logic [W-1:0] addr,
                          input logic [W-1:0] st, input logic [W-1:0] ld,
                          input int nerr, input int maxbusy);
        int busy_tot;
        int cyc;
        bit done;
        bit fatal;
        logic [W-1:0] exp_st;
        logic [W-1:0] exp_ld;
        logic [1:0] rs;
        busy_tot = 0;
        cyc = 0;
        done = 0;
        fatal = (nerr >= MR);
        exp_st = (k == 2'd2) ? st : {W{1'b0}};
        exp_ld = (k == 2'd1) ? ld : {W{1'b0}};
        script.delete();
        for (int a = 0; a <= nerr && a < MR; a++) begin
            int nb;
            nb = $urandom_range(maxbusy, 0);
            busy_tot += nb;
            repeat (nb) script.push_back(2'($urandom_range(1, 0)));
            script.push_back((a < nerr) ? 2'd3 : 2'd2);
        end
        bus.ramload = ld;
        while (!done && cyc < 80) begin
            tick();
            cyc++;
            if (bus.ihit || bus.dhit || bus.mem_err) begin
                done = 1;
                if (fatal) begin
                    check("fatal_ctl", {bus.mem_err, bus.halt_out, bus.ihit,
                                        bus.dhit, bus.ramREN, bus.ramWEN},
                          6'b110000);
                    check("fatal_lat", cyc, busy_tot + 2 * MR);
                end else begin
                    check("hit_ctl", {bus.mem_err, bus.halt_out, bus.ihit,
                                      bus.dhit, bus.ramREN, bus.ramWEN},
                          {2'b00, k == 2'd0, k != 2'd0, 2'b00});
                    check("hit_lat", cyc, busy_tot + 2 * nerr + 2);
                    if (k == 2'd0) begin
                        check("iload", bus.iload, ld);
                        last_i = ld;
                        icnt_m++;
                    end else begin
                        check("dload", bus.dload, exp_ld);
                        last_d = exp_ld;
                        dcnt_m++;
                    end
                end
            end else if (bus.ramREN || bus.ramWEN) begin
                check("strobe", {bus.ramREN, bus.ramWEN},
                      {k != 2'd2, k == 2'd2});
                check("ramaddr", bus.ramaddr, addr);
                check("ramstore", bus.ramstore, exp_st);
                rs = (script.size() > 0) ? script.pop_front() : 2'd1;
                bus.ramstate = rs;
            end
        end
        if (!done) check("timeout", 0, 1);
        bus.ramstate = 2'd0;
    endtask

    task automatic recover(input logic exp_err);
        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        repeat (3) tick();
        check("halted_hold", {bus.halt_out, bus.mem_err, bus.ramREN,
                              bus.ramWEN, bus.ihit, bus.dhit},
              {1'b1, exp_err, 4'b0000});
        check("halted_cnt", {bus.icount, bus.dcount}, {icnt_m, dcnt_m});
        nRST = 1'b0;
        clear_req();
        tick();
        nRST = 1'b1;
        tick();
        icnt_m = '0;
        dcnt_m = '0;
        last_i = '0;
        last_d = '0;
        post_check("post_rst");
    endtask

    logic [W-1:0] ia, da, ds;
    logic [2:0] req;
    logic [1:0] k;
    int nerr;

    initial begin
        bus.halt_in  = 1'b1;
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.iaddr    = '1;
        bus.daddr    = '1;
        bus.dstore   = '1;
        bus.ramload  = '1;
        bus.ramstate = 2'd3;
        nRST = 1'b0;
        tick();
        tick();
        check("rst_ctl", {bus.ihit, bus.dhit, bus.halt_out, bus.mem_err,
                          bus.ramREN, bus.ramWEN}, 0);
        check("rst_loads", {bus.iload, bus.dload}, 0);
        check("rst_ram", {bus.ramaddr, bus.ramstore}, 0);
        check("rst_cnt", {bus.icount, bus.dcount}, 0);
        clear_req();
        bus.ramstate = 2'd0;
        nRST = 1'b1;
        tick();
        tick();
        post_check("idle");

        bus.dREN = 1'b1;
        bus.daddr = 32'h0000_0200;
        bus.ramstate = 2'd1;
        tick();
        check("midrst_strobe", {bus.ramREN, bus.ramWEN, bus.ramaddr},
              {2'b10, 32'h0000_0200});
        nRST = 1'b0;
        tick();
        check("midrst_ctl", {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}, 0);
        check("midrst_cnt", {bus.icount, bus.dcount}, 0);
        clear_req();
        bus.ramstate = 2'd0;
        nRST = 1'b1;
        tick();
        post_check("midrst");

        bus.iREN = 1'b1;
        bus.iaddr = 32'h0000_0040;
        access(2'd0, 32'h0000_0040, 32'h0, 32'h3C01_0001, 0, 0);
        clear_req();
        tick();
        post_check("fetch");

        bus.iREN = 1'b1;
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        bus.iaddr = 32'h0000_0044;
        bus.daddr = 32'h0000_0100;
        bus.dstore = 32'hDEAD_BEEF;
        access(2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 0);
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        tick();
        post_check("prio_d");
        access(2'd0, 32'h0000_0044, 32'h0, 32'h2008_0005, 0, 0);
        clear_req();
        tick();
        post_check("prio_i");

        bus.dREN = 1'b1;
        bus.daddr = 32'h0000_0300;
        access(2'd1, 32'h0000_0300, 32'h0, 32'h1234_5678, 2, 0);
        clear_req();
        tick();
        post_check("retry");

        bus.dREN = 1'b1;
        access(2'd1, 32'h0000_0300, 32'h0, 32'h0BAD_0BAD, 3, 1);
        recover(1'b1);

        bus.halt_in = 1'b1;
        tick();
        check("halt", {bus.halt_out, bus.mem_err, bus.ramREN, bus.ramWEN},
              4'b1000);
        bus.halt_in = 1'b0;
        recover(1'b0);

        for (int t = 0; t < 40; t++) begin
            req = 3'($urandom_range(7, 1));
            ia = $urandom();
            da = $urandom();
            ds = $urandom();
            bus.iREN = req[0];
            bus.dREN = req[1];
            bus.dWEN = req[2];
            bus.iaddr = ia;
            bus.daddr = da;
            bus.dstore = ds;
            k = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
            nerr = ($urandom_range(9, 0) == 0) ? MR : $urandom_range(2, 0);
            access(k, (k == 2'd0) ? ia : da, ds, $urandom(), nerr, 2);
            if (nerr >= MR) begin
                recover(1'b1);
            end else begin
                if (k != 2'd0 && req[0]) begin
                    bus.dREN = 1'b0;
                    bus.dWEN = 1'b0;
                    tick();
                    post_check("rnd_d");
                    access(2'd0, ia, ds, $urandom(), $urandom_range(2, 0), 2);
                end
                clear_req();
                tick();
                post_check("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
